dds_sweep_ctrl: RTL
===================

Name: dds_sweep_ctrl

Overview:
- Linear frequency-sweep (chirp) controller directly upstream of the DDS core.
- Produces the DDS phase increment, accumulator enable and input data-valid.
- From a latched start increment, steps the increment by a signed step every dwell period, for a programmed number of steps.
- Single-shot or continuous (auto-restart) operation.

Parameters:
- M, 24, DDS accumulator/phase-increment wordlength (must match DDS M).
- CW, 16, width of step-count and dwell-count configuration words.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- ic_rst  in  1  synchronous, active-high reset.
- ic_start  in  1  start pulse; sampled only in IDLE.
- ic_stop  in  1  abort; sampled in RUN and IDLE.
- ic_cont  in  1  continuous mode, latched at start.
- id_p_start  in  M  initial phase increment, U[M,0], latched at start.
- id_p_step  in  M  increment step, S[M,0] two's complement, latched at start.
- id_n_steps  in  CW  number of steps after the first, U[CW,0], latched at start.
- id_dwell  in  CW  cycles per increment, U[CW,0]; 0 treated as 1; latched at start.
- od_p_ac  out  M  phase increment to DDS id_p_ac.
- oc_en_ac  out  1  DDS accumulator enable.
- oc_val_data  out  1  DDS input data-valid.
- oc_busy  out  1  high in RUN.
- oc_done  out  1  one-cycle pulse at end of single-shot sweep.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - All outputs and counters are 0.
  - Reset mid-sweep aborts immediately; no done pulse.
- All outputs are registered or decoded from registered state. No combinational input-to-output paths.
- States:
  - IDLE: en/val/busy = 0; od_p_ac holds its last value.
    - ic_start=1 and ic_stop=0: latch the config registers; od_p_ac <= id_p_start; step_cnt <= 0; dwell_cnt <= 0; go to RUN.
    - ic_start and ic_stop in the same cycle: stop wins; stay IDLE.
  - RUN: oc_en_ac = oc_val_data = oc_busy = 1. Priority order:
    - (1) ic_stop=1: go to IDLE at the next edge. od_p_ac holds. No done pulse.
    - (2) dwell_cnt /= dwell_eff-1: dwell_cnt++.
    - (3) dwell_cnt == dwell_eff-1, step_cnt < n_steps_r: dwell_cnt <= 0; step_cnt++; od_p_ac <= od_p_ac + p_step_r.
    - (4) dwell_cnt == dwell_eff-1, step_cnt == n_steps_r, cont_r=1: od_p_ac <= p_start_r; counters <= 0; stay RUN.
    - (5) dwell_cnt == dwell_eff-1, step_cnt == n_steps_r, cont_r=0: go to DONE.
    - ic_start is ignored in RUN. Config inputs are ignored outside the start cycle.
  - DONE: oc_done=1, en/val/busy=0, od_p_ac holds; unconditionally go to IDLE next edge.
- Latency:
  - Start sampled at edge k gives RUN outputs with od_p_ac=p_start in cycle k+1.
  - Sweep length is exactly (n_steps+1)*dwell_eff cycles of en=1.
- Arithmetic:
  - od_p_ac + p_step_r is an M-bit modulo-2^M add. Wrap-around is intended (negative step gives a down-chirp); no saturation.
  - dwell_eff = (dwell_r==0) ? 1 : dwell_r.
  - Counters are CW bits; they never exceed the latched limits.

Decomposition:
- Shared package dds_pkg: DDS_M=24 default constant and the state enum typedef sweep_state_t {IDLE, RUN, DONE}.
- One natural sub-module: dds_sweep_dwell_timer.
  - Loadable CW-bit counter with clear and a terminal-count flag for dwell_eff.
  - FSM, step counter and increment adder stay in the top module.

Test Plan:
- p_start=0x001000, step=0x000100, n_steps=3, dwell=2, cont=0, start at edge 0 -> od_p_ac = 0x001000 (cycles 1-2), 0x001100 (3-4), 0x001200 (5-6), 0x001300 (7-8); en=val=busy=1 for cycles 1-8; oc_done=1 only in cycle 9; od_p_ac stays 0x001300.
- p_start=0xFFFF00, step=0x000100, n_steps=1, dwell=1 -> od_p_ac 0xFFFF00 then 0x000000 (wrap); step=0xFFFF00 from 0x000100 -> 0x000100 then 0x000000 (down-chirp).
- dwell=0, n_steps=2 -> each increment held one cycle, identical to dwell=1; done pulse at cycle 4.
- cont=1, n_steps=1, dwell=1 -> od_p_ac alternates p_start, p_start+step indefinitely; oc_done never asserts; ic_stop in cycle 5 -> IDLE at cycle 6, en=0, no done.
- Start pulse during RUN with different config -> ignored, sequence unchanged; start+stop same cycle in IDLE -> stays IDLE.
- ic_rst=1 mid-sweep (cycle 3) -> cycle 4: all outputs 0, IDLE; a subsequent start runs a full fresh sweep.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared constants and state encoding for the DDS sweep controller.
// DDS_M must track the phase-accumulator width of the downstream DDS core.
package dds_pkg;

  localparam int DDS_M  = 24;
  localparam int DDS_CW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/dds_sweep_dwell_timer.sv
// Dwell timer: counts cycles spent on one phase increment and flags the last one.
// A zero dwell programs a one-cycle dwell.
module dds_sweep_dwell_timer
  import dds_pkg::*;
#(
  parameter int CW = DDS_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] dwell,
  input  logic          advance,
  output logic          tc
);

  logic [CW-1:0] limit_q, limit_d;
  logic [CW-1:0] count_q, count_d;

  // The limit is stored as dwell_eff-1 so the terminal test is a plain compare.
  always_comb begin
    limit_d = limit_q;
    count_d = count_q;
    if (load) begin
      limit_d = (dwell == '0) ? '0 : (dwell - CW'(1));
      count_d = '0;
    end else if (advance) begin
      count_d = tc ? '0 : (count_q + CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      limit_q <= '0;
      count_q <= '0;
    end else begin
      limit_q <= limit_d;
      count_q <= count_d;
    end
  end

  assign tc = (count_q == limit_q);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear chirp controller feeding the DDS phase increment, enable and data-valid.
// Steps the increment by a signed step every dwell period, single-shot or continuous.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int M  = DDS_M,
  parameter int CW = DDS_CW
) (
  input  logic          clk,
  input  logic          ic_rst,
  input  logic          ic_start,
  input  logic          ic_stop,
  input  logic          ic_cont,
  input  logic [M-1:0]  id_p_start,
  input  logic [M-1:0]  id_p_step,
  input  logic [CW-1:0] id_n_steps,
  input  logic [CW-1:0] id_dwell,
  output logic [M-1:0]  od_p_ac,
  output logic          oc_en_ac,
  output logic          oc_val_data,
  output logic          oc_busy,
  output logic          oc_done
);

  sweep_state_t  state_q, state_d;
  logic [M-1:0]  p_ac_q, p_ac_d;
  logic [CW-1:0] step_cnt_q, step_cnt_d;
  logic [M-1:0]  p_start_q, p_start_d;
  logic [M-1:0]  p_step_q, p_step_d;
  logic [CW-1:0] n_steps_q, n_steps_d;
  logic          cont_q, cont_d;

  logic start_fire;
  logic run_go;
  logic dwell_tc;
  logic last_step;

  assign start_fire = (state_q == IDLE) && ic_start && !ic_stop;
  assign run_go     = (state_q == RUN) && !ic_stop;
  assign last_step  = !(step_cnt_q < n_steps_q);

  dds_sweep_dwell_timer #(
    .CW (CW)
  ) u_dwell_timer (
    .clk     (clk),
    .rst     (ic_rst),
    .load    (start_fire),
    .dwell   (id_dwell),
    .advance (run_go),
    .tc      (dwell_tc)
  );

  always_ff @(posedge clk) begin
    if (ic_rst) begin
      state_q    <= IDLE;
      p_ac_q     <= '0;
      step_cnt_q <= '0;
      p_start_q  <= '0;
      p_step_q   <= '0;
      n_steps_q  <= '0;
      cont_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_ac_q     <= p_ac_d;
      step_cnt_q <= step_cnt_d;
      p_start_q  <= p_start_d;
      p_step_q   <= p_step_d;
      n_steps_q  <= n_steps_d;
      cont_q     <= cont_d;
    end
  end

  // Stop beats start in IDLE and beats every step decision in RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_fire) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (ic_stop) begin
          state_d = IDLE;
        end else if (dwell_tc && last_step && !cont_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Increment arithmetic wraps modulo 2^M so a negative step yields a down-chirp.
  always_comb begin
    p_ac_d     = p_ac_q;
    step_cnt_d = step_cnt_q;
    p_start_d  = p_start_q;
    p_step_d   = p_step_q;
    n_steps_d  = n_steps_q;
    cont_d     = cont_q;
    if (start_fire) begin
      p_start_d  = id_p_start;
      p_step_d   = id_p_step;
      n_steps_d  = id_n_steps;
      cont_d     = ic_cont;
      p_ac_d     = id_p_start;
      step_cnt_d = '0;
    end else if (run_go && dwell_tc) begin
      if (!last_step) begin
        step_cnt_d = step_cnt_q + CW'(1);
        p_ac_d     = p_ac_q + p_step_q;
      end else if (cont_q) begin
        step_cnt_d = '0;
        p_ac_d     = p_start_q;
      end
    end
  end

  always_comb begin
    od_p_ac     = p_ac_q;
    oc_en_ac    = (state_q == RUN);
    oc_val_data = (state_q == RUN);
    oc_busy     = (state_q == RUN);
    oc_done     = (state_q == DONE);
  end

endmodule
